// File: rtl/fc_pkg.sv
// Fast-command link shared definitions.
// Symbol codes and command indices for encoder and decoder.
package fc_pkg;

  localparam int FC_NUM_CMDS = 10;

  localparam logic [7:0] FC_IDLE      = 8'hF0;
  localparam logic [7:0] FC_LINKRESET = 8'h33;
  localparam logic [7:0] FC_BCR       = 8'h5A;
  localparam logic [7:0] FC_SYNCTRIG  = 8'h55;
  localparam logic [7:0] FC_L1A_CR    = 8'h66;
  localparam logic [7:0] FC_CHARGEINJ = 8'h69;
  localparam logic [7:0] FC_L1A       = 8'h96;
  localparam logic [7:0] FC_L1A_BCR   = 8'h99;
  localparam logic [7:0] FC_WS_START  = 8'hA5;
  localparam logic [7:0] FC_WS_STOP   = 8'hAA;

  typedef enum logic [3:0] {
    CMD_IDLE      = 4'd0,
    CMD_LINKRESET = 4'd1,
    CMD_BCR       = 4'd2,
    CMD_SYNCTRIG  = 4'd3,
    CMD_L1A_CR    = 4'd4,
    CMD_CHARGEINJ = 4'd5,
    CMD_L1A       = 4'd6,
    CMD_L1A_BCR   = 4'd7,
    CMD_WS_START  = 4'd8,
    CMD_WS_STOP   = 4'd9
  } fc_cmd_e;

  typedef enum logic {
    ST_NORMAL    = 1'b0,
    ST_SLIP_HOLD = 1'b1
  } fc_slip_state_e;

  function automatic logic [7:0] fc_symbol(input logic [3:0] idx);
    logic [7:0] s;
    case (idx)
      CMD_LINKRESET: s = FC_LINKRESET;
      CMD_BCR:       s = FC_BCR;
      CMD_SYNCTRIG:  s = FC_SYNCTRIG;
      CMD_L1A_CR:    s = FC_L1A_CR;
      CMD_CHARGEINJ: s = FC_CHARGEINJ;
      CMD_L1A:       s = FC_L1A;
      CMD_L1A_BCR:   s = FC_L1A_BCR;
      CMD_WS_START:  s = FC_WS_START;
      CMD_WS_STOP:   s = FC_WS_STOP;
      default:       s = FC_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fc_cmd_fifo.sv
// Synchronous command FIFO with count-based full/empty.
// Head entry is presented combinationally on data_o.
module fc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    unique case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents are only meaningful below count.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fc_encoder_tx.sv
// Fast-command transmitter: queues command indices and
// serializes 8-bit symbols MSB-first with bit-slip support.
module fc_encoder_tx
  import fc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk320,
  input  logic       rst,
  input  logic       cmdValid,
  input  logic [3:0] cmdSel,
  output logic       cmdReady,
  input  logic       slipReq,
  output logic       fc,
  output logic       frameStart,
  output logic       illegalCmd
);

  fc_slip_state_e state_q, state_d;

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic       slipPend_q, slipPend_d;
  logic       fc_q, fc_d;
  logic       fs_q, fs_d;
  logic       ill_q, ill_d;
  logic       rdyEn_q;

  logic       full, empty;
  logic       accept, legal, push, pop;
  logic [3:0] head;
  logic [7:0] nextSym;

  assign cmdReady   = rdyEn_q && !full;
  assign accept     = cmdValid && cmdReady;
  assign legal      = (cmdSel < 4'(FC_NUM_CMDS));
  assign push       = accept && legal;
  assign ill_d      = accept && !legal;
  assign nextSym    = empty ? FC_IDLE : fc_symbol(head);

  assign fc         = fc_q;
  assign frameStart = fs_q;
  assign illegalCmd = ill_q;

  fc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk_i   (clk320),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (cmdSel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Serializer next-state: shift, frame boundary load, slip hold.
  always_comb begin
    state_d    = state_q;
    shreg_d    = {shreg_q[6:0], 1'b0};
    bitCnt_d   = bitCnt_q + 3'd1;
    slipPend_d = slipPend_q | slipReq;
    fc_d       = shreg_q[7];
    fs_d       = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      ST_NORMAL: begin
        fs_d = (bitCnt_q == 3'd0);
        if (bitCnt_q == 3'd7) begin
          if (slipPend_q) begin
            state_d    = ST_SLIP_HOLD;
            shreg_d    = shreg_q;
            bitCnt_d   = 3'd7;
            slipPend_d = 1'b0;
          end else begin
            pop      = !empty;
            shreg_d  = nextSym;
            bitCnt_d = 3'd0;
          end
        end
      end
      ST_SLIP_HOLD: begin
        state_d  = ST_NORMAL;
        pop      = !empty;
        shreg_d  = nextSym;
        bitCnt_d = 3'd0;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Slip state register.
  always_ff @(posedge clk320) begin
    if (rst) state_q <= ST_NORMAL;
    else     state_q <= state_d;
  end

  // Serializer datapath and status registers.
  always_ff @(posedge clk320) begin
    if (rst) begin
      shreg_q    <= FC_IDLE;
      bitCnt_q   <= 3'd0;
      slipPend_q <= 1'b0;
      fc_q       <= 1'b0;
      fs_q       <= 1'b0;
      ill_q      <= 1'b0;
      rdyEn_q    <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bitCnt_q   <= bitCnt_d;
      slipPend_q <= slipPend_d;
      fc_q       <= fc_d;
      fs_q       <= fs_d;
      ill_q      <= ill_d;
      rdyEn_q    <= 1'b1;
    end
  end

endmodule
